// File: rtl/laser_projector_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | laser_projector_pkg: point table, DAC command format and timing constants |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
package laser_projector_pkg;

  localparam int BIT_CLKS   = 4;
  localparam int DWELL_UNIT = 64;
  localparam int NUM_POINTS = 9;

  localparam logic [2:0]  DAC_CMD     = 3'b011;
  localparam logic        CH_X        = 1'b0;
  localparam logic        CH_Y        = 1'b1;
  localparam logic [11:0] PADDLE_UP   = 12'h600;
  localparam logic [11:0] PADDLE_DOWN = 12'h300;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_X_WORD = 3'd1,
    ST_GAP    = 3'd2,
    ST_Y_WORD = 3'd3,
    ST_LATCH  = 3'd4,
    ST_DWELL  = 3'd5
  } proj_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SETUP = 2'd1,
    TX_SHIFT = 2'd2,
    TX_TAIL  = 2'd3
  } tx_state_t;

  function automatic logic [15:0] dac_word(input logic ch, input logic [11:0] data);
    return {ch, DAC_CMD, data};
  endfunction

  function automatic logic [11:0] point_x(input logic [3:0] idx);
    case (idx)
      4'd1, 4'd2: return 12'hE00;
      4'd5:       return 12'h500;
      4'd6:       return 12'h700;
      4'd7:       return 12'hB00;
      4'd8:       return 12'h900;
      default:    return 12'h200;
    endcase
  endfunction

  // Points 6 and 8 are the paddle bars; their height follows the synced buttons.
  function automatic logic [11:0] point_y(input logic [3:0] idx, input logic pl, input logic pr);
    case (idx)
      4'd2, 4'd3: return 12'hE00;
      4'd5, 4'd7: return 12'h400;
      4'd6:       return pl ? PADDLE_UP : PADDLE_DOWN;
      4'd8:       return pr ? PADDLE_UP : PADDLE_DOWN;
      default:    return 12'h200;
    endcase
  endfunction

  function automatic logic [2:0] point_rgb(input logic [3:0] idx);
    case (idx)
      4'd1, 4'd2, 4'd3, 4'd4: return 3'b010;
      4'd6, 4'd8:             return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/laser_projector_full_dac_spi_tx.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | dac_spi_tx: 16-bit mode-0 serializer, csn setup and hold of one clk each  |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module dac_spi_tx (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] word,
  output logic        mosi,
  output logic        sclk,
  output logic        csn,
  output logic        done
);
  import laser_projector_pkg::*;

  localparam int PH_W = $clog2(BIT_CLKS);

  tx_state_t       state, state_nxt;
  logic [PH_W-1:0] phase;
  logic [3:0]      bit_cnt;
  logic [15:0]     shreg;
  logic            last_phase;

  assign last_phase = (phase == PH_W'(BIT_CLKS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE:  if (start) state_nxt = TX_SETUP;
      TX_SETUP: state_nxt = TX_SHIFT;
      TX_SHIFT: if (last_phase && bit_cnt == 4'd15) state_nxt = TX_TAIL;
      TX_TAIL:  state_nxt = TX_IDLE;
      default:  state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= TX_IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == TX_TAIL);
      case (state)
        TX_IDLE: if (start) begin
          shreg   <= word;
          phase   <= '0;
          bit_cnt <= '0;
        end
        TX_SHIFT: begin
          phase <= last_phase ? '0 : phase + 1'b1;
          // Next bit is presented on the same edge that drops sclk.
          if (last_phase) begin
            shreg   <= {shreg[14:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign csn  = (state == TX_IDLE);
  assign sclk = (state == TX_SHIFT) && (phase >= PH_W'(BIT_CLKS / 2));
  assign mosi = (state != TX_IDLE) && shreg[15];

endmodule
`default_nettype wire

// File: rtl/laser_projector_full.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | laser_projector_full: walks a 9-point vector frame out to an X/Y DAC     |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module laser_projector_full (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dip_sw,
  input  logic       paddle_l,
  input  logic       paddle_r,
  output logic [2:0] laser_rgb,
  output logic       dac_mosi,
  output logic       dac_sclk,
  output logic       dac_csn,
  output logic       dac_latchn,
  output logic [7:0] debug_led
);
  import laser_projector_pkg::*;

  localparam int DWELL_W = 10;

  logic               pl_meta, pl_sync, pr_meta, pr_sync;
  proj_state_t        state, state_nxt;
  logic [3:0]         point_idx, tgt_idx;
  logic               frame_toggle;
  logic [15:0]        y_word_q, tx_word;
  logic [2:0]         rgb_pt_q, laser_q;
  logic               latch_cnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               x_start, gap_start, tx_start, tx_done;
  logic               unused_sw;

  assign unused_sw = ^dip_sw[6:4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pl_meta <= 1'b0;
      pl_sync <= 1'b0;
      pr_meta <= 1'b0;
      pr_sync <= 1'b0;
    end else begin
      pl_meta <= paddle_l;
      pl_sync <= pl_meta;
      pr_meta <= paddle_r;
      pr_sync <= pr_meta;
    end
  end

  assign tgt_idx = (state == ST_IDLE || point_idx == 4'(NUM_POINTS - 1)) ? 4'd0
                                                                          : point_idx + 4'd1;

  always_comb begin
    state_nxt = state;
    x_start   = 1'b0;
    gap_start = 1'b0;
    tx_word   = dac_word(CH_X, point_x(tgt_idx));
    case (state)
      ST_IDLE: begin
        x_start   = 1'b1;
        state_nxt = ST_X_WORD;
      end
      ST_X_WORD: if (tx_done) state_nxt = ST_GAP;
      ST_GAP: begin
        gap_start = 1'b1;
        tx_word   = y_word_q;
        state_nxt = ST_Y_WORD;
      end
      ST_Y_WORD: if (tx_done) state_nxt = ST_LATCH;
      ST_LATCH:  if (latch_cnt) state_nxt = ST_DWELL;
      ST_DWELL: if (dwell_cnt == '0) begin
        x_start   = 1'b1;
        state_nxt = ST_X_WORD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign tx_start = x_start | gap_start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      point_idx    <= '0;
      frame_toggle <= 1'b0;
      y_word_q     <= '0;
      rgb_pt_q     <= '0;
      latch_cnt    <= 1'b0;
      dwell_cnt    <= '0;
      laser_q      <= '0;
    end else begin
      state <= state_nxt;
      // Paddle height is frozen for the whole point when its X word starts.
      if (x_start) begin
        point_idx <= tgt_idx;
        if (state == ST_DWELL && tgt_idx == 4'd0) frame_toggle <= ~frame_toggle;
        y_word_q <= dac_word(CH_Y, point_y(tgt_idx, pl_sync, pr_sync));
        rgb_pt_q <= point_rgb(tgt_idx);
      end
      latch_cnt <= (state == ST_LATCH) ? ~latch_cnt : 1'b0;
      if (state == ST_LATCH && latch_cnt)
        dwell_cnt <= DWELL_W'(DWELL_UNIT * (int'(dip_sw[3:0]) + 1) - 1);
      else if (state == ST_DWELL && dwell_cnt != '0)
        dwell_cnt <= dwell_cnt - 1'b1;
      if (state == ST_Y_WORD && tx_done)
        laser_q <= rgb_pt_q & ~{3{dip_sw[7]}};
      else if (dip_sw[7])
        laser_q <= 3'b000;
    end
  end

  dac_spi_tx u_dac_spi_tx (
    .clk   (clk),
    .reset (reset),
    .start (tx_start),
    .word  (tx_word),
    .mosi  (dac_mosi),
    .sclk  (dac_sclk),
    .csn   (dac_csn),
    .done  (tx_done)
  );

  assign laser_rgb  = laser_q;
  assign dac_latchn = (state != ST_LATCH);
  assign debug_led  = {point_idx, frame_toggle, pr_sync, pl_sync, ~dip_sw[7]};

endmodule
`default_nettype wire

// File: tb/tb_laser_projector_full.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_laser_projector_full: directed frame walk with SPI word decoding      |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module tb_laser_projector_full;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] dip_sw = 8'h00;
  logic       paddle_l = 1'b0;
  logic       paddle_r = 1'b0;
  logic [2:0] laser_rgb;
  logic       dac_mosi, dac_sclk, dac_csn, dac_latchn;
  logic [7:0] debug_led;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int last_lr = 0;
  int last_xf = 0;

  laser_projector_full dut (
    .clk        (clk),
    .reset      (reset),
    .dip_sw     (dip_sw),
    .paddle_l   (paddle_l),
    .paddle_r   (paddle_r),
    .laser_rgb  (laser_rgb),
    .dac_mosi   (dac_mosi),
    .dac_sclk   (dac_sclk),
    .dac_csn    (dac_csn),
    .dac_latchn (dac_latchn),
    .debug_led  (debug_led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic get_word(output logic [15:0] w, output int tf, output int tr);
    int   n;
    int   nb;
    logic prev;
    w  = '0;
    nb = 0;
    n  = 0;
    while (dac_csn !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("csn_fall_in_time", 32'(n < 2000), 32'd1);
    tf   = cyc;
    prev = dac_sclk;
    n    = 0;
    while (dac_csn === 1'b0 && n < 200) begin
      if (dac_sclk === 1'b1 && prev === 1'b0) begin
        w = {w[14:0], dac_mosi};
        nb++;
      end
      prev = dac_sclk;
      @(negedge clk);
      n++;
    end
    tr = cyc;
    chk("sclk_rises", 32'(nb), 32'd16);
  endtask

  task automatic do_point(input logic [15:0] ex, input logic [15:0] ey, input logic [2:0] er,
                          input logic [3:0] eidx, input logic etog, input int edw);
    logic [15:0] wx, wy;
    int xf, xr, yf, yr, lf, lr, n;
    get_word(wx, xf, xr);
    last_xf = xf;
    if (edw > 0) chk("dwell", 32'(xf - last_lr), 32'(edw));
    chk("x_word", {16'h0, wx}, {16'h0, ex});
    chk("x_csn_len", 32'(xr - xf), 32'd66);
    get_word(wy, yf, yr);
    chk("csn_gap", 32'(yf - xr), 32'd2);
    chk("y_word", {16'h0, wy}, {16'h0, ey});
    n = 0;
    while (dac_latchn !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    lf = cyc;
    chk("latch_delay", 32'(lf - yr), 32'd1);
    chk("laser_rgb", {29'h0, laser_rgb}, {29'h0, er});
    chk("point_frame", {27'h0, debug_led[7:3]}, {27'h0, eidx, etog});
    n = 0;
    while (dac_latchn === 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    lr = cyc;
    chk("latch_len", 32'(lr - lf), 32'd2);
    last_lr = lr;
  endtask

  initial begin
    logic [15:0] w;
    int tf, tr, n, c_rel, latch_seen;

    repeat (3) @(negedge clk);
    chk("rst_csn", {31'h0, dac_csn}, 32'd1);
    chk("rst_latchn", {31'h0, dac_latchn}, 32'd1);
    chk("rst_sclk", {31'h0, dac_sclk}, 32'd0);
    chk("rst_mosi", {31'h0, dac_mosi}, 32'd0);
    chk("rst_rgb", {29'h0, laser_rgb}, 32'd0);
    chk("rst_debug", {24'h0, debug_led}, 32'h01);
    paddle_l = 1'b1;
    paddle_r = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sync_held", {24'h0, debug_led}, 32'h01);
    paddle_l = 1'b0;
    paddle_r = 1'b0;
    repeat (3) @(negedge clk);

    reset = 1'b1;
    c_rel = cyc;
    do_point(16'h3200, 16'hB200, 3'b000, 4'd0, 1'b0, 0);
    chk("first_csn_fall", 32'(last_xf - c_rel), 32'd1);
    do_point(16'h3E00, 16'hB200, 3'b010, 4'd1, 1'b0, 64);
    do_point(16'h3E00, 16'hBE00, 3'b010, 4'd2, 1'b0, 64);
    do_point(16'h3200, 16'hBE00, 3'b010, 4'd3, 1'b0, 64);
    do_point(16'h3200, 16'hB200, 3'b010, 4'd4, 1'b0, 64);
    paddle_l = 1'b1;
    do_point(16'h3500, 16'hB400, 3'b000, 4'd5, 1'b0, 64);
    do_point(16'h3700, 16'hB600, 3'b100, 4'd6, 1'b0, 64);
    paddle_l = 1'b0;
    do_point(16'h3B00, 16'hB400, 3'b000, 4'd7, 1'b0, 64);
    do_point(16'h3900, 16'hB300, 3'b100, 4'd8, 1'b0, 64);

    // Second frame: toggle flips, blanking, longer dwell, paddles swapped.
    do_point(16'h3200, 16'hB200, 3'b000, 4'd0, 1'b1, 64);
    do_point(16'h3E00, 16'hB200, 3'b010, 4'd1, 1'b1, 64);
    dip_sw = 8'h80;
    @(negedge clk);
    chk("blank_rgb", {29'h0, laser_rgb}, 32'd0);
    chk("blank_led0", {31'h0, debug_led[0]}, 32'd0);
    do_point(16'h3E00, 16'hBE00, 3'b000, 4'd2, 1'b1, 64);
    dip_sw = 8'h01;
    do_point(16'h3200, 16'hBE00, 3'b010, 4'd3, 1'b1, 64);
    dip_sw = 8'h00;
    do_point(16'h3200, 16'hB200, 3'b010, 4'd4, 1'b1, 128);
    do_point(16'h3500, 16'hB400, 3'b000, 4'd5, 1'b1, 64);
    do_point(16'h3700, 16'hB300, 3'b100, 4'd6, 1'b1, 64);
    paddle_r = 1'b1;
    do_point(16'h3B00, 16'hB400, 3'b000, 4'd7, 1'b1, 64);
    do_point(16'h3900, 16'hB600, 3'b100, 4'd8, 1'b1, 64);
    paddle_r = 1'b0;

    // Third frame: abort in the middle of point 2's Y word.
    do_point(16'h3200, 16'hB200, 3'b000, 4'd0, 1'b0, 64);
    do_point(16'h3E00, 16'hB200, 3'b010, 4'd1, 1'b0, 64);
    get_word(w, tf, tr);
    chk("abort_x_word", {16'h0, w}, 32'h3E00);
    n = 0;
    while (dac_csn !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    chk("abort_in_y", {31'h0, dac_csn}, 32'd0);
    reset = 1'b0;
    #1;
    chk("abort_csn", {31'h0, dac_csn}, 32'd1);
    chk("abort_sclk", {31'h0, dac_sclk}, 32'd0);
    chk("abort_mosi", {31'h0, dac_mosi}, 32'd0);
    chk("abort_latchn", {31'h0, dac_latchn}, 32'd1);
    chk("abort_rgb", {29'h0, laser_rgb}, 32'd0);
    chk("abort_idx", {27'h0, debug_led[7:3]}, 32'd0);
    latch_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (dac_latchn === 1'b0) latch_seen++;
    end
    chk("abort_no_latch", 32'(latch_seen), 32'd0);
    reset = 1'b1;
    c_rel = cyc;
    do_point(16'h3200, 16'hB200, 3'b000, 4'd0, 1'b0, 0);
    chk("restart_csn_fall", 32'(last_xf - c_rel), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
